// File: rtl/gpr_exec_pkg.sv
// Shared definitions for the clocked GPR execution unit.
// Contents: opcode values, instruction field positions, FSM state enum and
// bit positions inside the 4-bit flags word {sign, zero, carry, overflow}.
package gpr_exec_pkg;

    // Instruction field positions within the 32-bit IR
    localparam int OPER_LSB     = 27;
    localparam int OPER_W       = 5;
    localparam int RDST_LSB     = 22;
    localparam int RSRC1_LSB    = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_LSB    = 11;
    localparam int ISRC_W       = 16;

    // Opcodes; 12..31 are illegal
    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_RETIRE = 2'd2
    } state_t;

    // Bit positions inside the flags word
    localparam int FLAG_SIGN  = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/gpr_exec_unit_mul.sv
// Iterative shift-add multiplier retiring MUL_ITER multiplier bits per cycle.
// Ports: clk, sys_rst (sync, active high), start (load a/b and do first step),
//        a/b operands, busy (steps outstanding), done (one-cycle pulse once
//        product is final), product (2*DATA_W, valid while done is high).
// The first partial product is accumulated at the start edge, so after
// DATA_W/MUL_ITER edges the product is complete and done is raised.
module gpr_seq_mul #(
    parameter int DATA_W   = 16,
    parameter int MUL_ITER = 1
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int STEPS = DATA_W / MUL_ITER;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [2*DATA_W-1:0] mcand_r;
    logic [2*DATA_W-1:0] acc_r;
    logic [DATA_W-1:0]   mplier_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [2*DATA_W-1:0] partial_s;

    // Sum of the shifted multiplicand for each set bit of the retired slice
    function automatic logic [2*DATA_W-1:0] partial(input logic [2*DATA_W-1:0] m,
                                                    input logic [MUL_ITER-1:0] bits);
        logic [2*DATA_W-1:0] sum;
        sum = {(2*DATA_W){1'b0}};
        for (int i = 0; i < MUL_ITER; i++) begin
            if (bits[i]) begin
                sum = sum + (m << i);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    // Partial product for this cycle: from fresh operands on start, else from state
    always_comb begin
        partial_s = {(2*DATA_W){1'b0}};
        if (start) begin
            partial_s = partial({{DATA_W{1'b0}}, a}, b[MUL_ITER-1:0]);
        end else begin
            partial_s = partial(mcand_r, mplier_r[MUL_ITER-1:0]);
        end
    end

    // Shift-add datapath and step counter
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            mcand_r  <= {(2*DATA_W){1'b0}};
            acc_r    <= {(2*DATA_W){1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= partial_s;
            mcand_r  <= {{DATA_W{1'b0}}, a} << MUL_ITER;
            mplier_r <= b >> MUL_ITER;
            cnt_r    <= CNT_W'(1);
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            acc_r    <= acc_r + partial_s;
            mcand_r  <= mcand_r << MUL_ITER;
            mplier_r <= mplier_r >> MUL_ITER;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(STEPS - 1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/gpr_exec_unit.sv
// Clocked GPR execution unit: accepts one instruction per ir_valid/ir_ready
// handshake, executes it against a registered GPR file and SGPR, updates the
// flags and pulses done (plus err for illegal opcodes) in the RETIRE state.
// Ports: clk, sys_rst (sync, active high), ir_in/ir_valid/ir_ready handshake,
//        done/err retire pulses, flags {sign,zero,carry,overflow},
//        dbg_addr/dbg_data combinational GPR read, sgpr contents.
module gpr_exec_unit
    import gpr_exec_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREG     = 32,
    parameter int MUL_ITER = 1
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [31:0]             ir_in,
    input  logic                    ir_valid,
    output logic                    ir_ready,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              flags,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    output logic [DATA_W-1:0]       sgpr
);
    localparam int AW  = $clog2(NREG);
    localparam int MSB = DATA_W - 1;

    state_t              state_r;
    logic [DATA_W-1:0]   gpr_r [NREG];
    logic [DATA_W-1:0]   sgpr_r;
    logic [3:0]          flags_r;
    logic                done_r;
    logic                err_r;
    logic [AW-1:0]       mul_rdst_r;

    logic [4:0]          op_s;
    logic [AW-1:0]       rdst_s;
    logic [AW-1:0]       rsrc1_s;
    logic [AW-1:0]       rsrc2_s;
    logic                imm_mode_s;
    logic [DATA_W-1:0]   imm_s;
    logic [DATA_W-1:0]   op1_s;
    logic [DATA_W-1:0]   op2_s;
    logic [DATA_W-1:0]   src_s;
    logic [DATA_W-1:0]   result_s;
    logic [DATA_W:0]     sum_s;
    logic                carry_s;
    logic                ovf_s;
    logic                legal_s;
    logic                is_mul_s;
    logic                accept_s;
    logic [3:0]          flags_next_s;
    logic [3:0]          mul_flags_s;
    logic                mul_start_s;
    logic                mul_busy_s;
    logic                mul_done_s;
    logic [2*DATA_W-1:0] mul_prod_s;

    assign op_s       = ir_in[OPER_LSB +: OPER_W];
    assign rdst_s     = ir_in[RDST_LSB +: AW];
    assign rsrc1_s    = ir_in[RSRC1_LSB +: AW];
    assign rsrc2_s    = ir_in[RSRC2_LSB +: AW];
    assign imm_mode_s = ir_in[IMM_MODE_BIT];

    // Immediate: zero-extend isrc, or truncate when DATA_W is narrower
    always_comb begin
        imm_s = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            imm_s[i] = (i < ISRC_W) ? ir_in[i] : 1'b0;
        end
    end

    assign op1_s    = gpr_r[rsrc1_s];
    assign op2_s    = imm_mode_s ? imm_s : gpr_r[rsrc2_s];
    assign src_s    = imm_mode_s ? imm_s : op1_s;
    assign sum_s    = {1'b0, op1_s} + {1'b0, op2_s};
    assign ir_ready = (state_r == ST_IDLE) & ~sys_rst;
    assign accept_s = ir_valid & ir_ready;

    // Single-cycle ALU and opcode legality
    always_comb begin
        result_s = {DATA_W{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        legal_s  = 1'b1;
        is_mul_s = 1'b0;
        case (op_s)
            OP_MOVSGPR: result_s = sgpr_r;
            OP_MOV:     result_s = src_s;
            OP_ADD: begin
                result_s = sum_s[DATA_W-1:0];
                carry_s  = sum_s[DATA_W];
                ovf_s    = (op1_s[MSB] == op2_s[MSB]) && (result_s[MSB] != op1_s[MSB]);
            end
            OP_SUB: begin
                result_s = op1_s - op2_s;
                carry_s  = (op1_s < op2_s);
                ovf_s    = (op1_s[MSB] != op2_s[MSB]) && (result_s[MSB] != op1_s[MSB]);
            end
            OP_MUL:     is_mul_s = 1'b1;
            OP_OR:      result_s = op1_s | op2_s;
            OP_AND:     result_s = op1_s & op2_s;
            OP_XOR:     result_s = op1_s ^ op2_s;
            OP_XNOR:    result_s = ~(op1_s ^ op2_s);
            OP_NAND:    result_s = ~(op1_s & op2_s);
            OP_NOR:     result_s = ~(op1_s | op2_s);
            OP_NOT:     result_s = ~src_s;
            default:    legal_s  = 1'b0;
        endcase
    end

    // Flag words for the single-cycle result and the multiplier result
    always_comb begin
        flags_next_s              = 4'b0000;
        flags_next_s[FLAG_SIGN]   = result_s[MSB];
        flags_next_s[FLAG_ZERO]   = (result_s == {DATA_W{1'b0}});
        flags_next_s[FLAG_CARRY]  = carry_s;
        flags_next_s[FLAG_OVF]    = ovf_s;
        mul_flags_s               = 4'b0000;
        mul_flags_s[FLAG_SIGN]    = mul_prod_s[MSB];
        mul_flags_s[FLAG_ZERO]    = (mul_prod_s[DATA_W-1:0] == {DATA_W{1'b0}});
        mul_flags_s[FLAG_CARRY]   = (mul_prod_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
        mul_flags_s[FLAG_OVF]     = (mul_prod_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
    end

    assign mul_start_s = accept_s & is_mul_s & ~mul_busy_s;

    gpr_seq_mul #(
        .DATA_W   (DATA_W),
        .MUL_ITER (MUL_ITER)
    ) u_mul (
        .clk     (clk),
        .sys_rst (sys_rst),
        .start   (mul_start_s),
        .a       (op1_s),
        .b       (op2_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Control FSM, register file, SGPR, flags and retire pulses
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_r[i] <= {DATA_W{1'b0}};
            end
            sgpr_r     <= {DATA_W{1'b0}};
            flags_r    <= 4'b0000;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            mul_rdst_r <= {AW{1'b0}};
            state_r    <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (accept_s) begin
                        if (is_mul_s) begin
                            mul_rdst_r <= rdst_s;
                            state_r    <= ST_MUL;
                        end else begin
                            // Illegal opcodes retire with err and leave state untouched
                            if (legal_s) begin
                                gpr_r[rdst_s] <= result_s;
                                flags_r       <= flags_next_s;
                            end else begin
                                flags_r <= flags_r;
                            end
                            done_r  <= 1'b1;
                            err_r   <= ~legal_s;
                            state_r <= ST_RETIRE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    err_r <= 1'b0;
                    if (mul_done_s) begin
                        gpr_r[mul_rdst_r] <= mul_prod_s[DATA_W-1:0];
                        sgpr_r            <= mul_prod_s[2*DATA_W-1:DATA_W];
                        flags_r           <= mul_flags_s;
                        done_r            <= 1'b1;
                        state_r           <= ST_RETIRE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= ST_MUL;
                    end
                end
                ST_RETIRE: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign done     = done_r;
    assign err      = err_r;
    assign flags    = flags_r;
    assign sgpr     = sgpr_r;
    assign dbg_data = gpr_r[dbg_addr];

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Self-checking bench for gpr_exec_unit (DATA_W=16, NREG=32, MUL_ITER=1):
// directed scenarios followed by random instructions, all compared against
// an arithmetic reference model of the register file, SGPR and flags.
module tb_gpr_exec_unit;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [31:0] ir_in;
    logic        ir_valid;
    logic        ir_ready;
    logic        done;
    logic        err;
    logic [3:0]  flags;
    logic [4:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] sgpr;

    int          n_checks = 0;
    int          n_errors = 0;

    int          m_gpr [32];
    int          m_sgpr;
    logic [3:0]  m_flags;

    gpr_exec_unit #(.DATA_W(16), .NREG(32), .MUL_ITER(1)) dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .ir_in    (ir_in),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .done     (done),
        .err      (err),
        .flags    (flags),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .sgpr     (sgpr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int op, input int rd, input int s1, input int imm);
        return {5'(op), 5'(rd), 5'(s1), 1'b1, 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int op, input int rd, input int s1, input int s2);
        return {5'(op), 5'(rd), 5'(s1), 1'b0, 5'(s2), 11'd0};
    endfunction

    function automatic int to_signed(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference model: applies one instruction to the model state
    task automatic model_exec(input logic [31:0] ir, output int lat, output bit e);
        int op, rd, s1, s2, imm, a, b, r, sr;
        bit im, c, v;
        longint p;
        op  = int'(ir[31:27]);
        rd  = int'(ir[26:22]);
        s1  = int'(ir[21:17]);
        im  = ir[16];
        s2  = int'(ir[15:11]);
        imm = int'(ir[15:0]);
        a   = m_gpr[s1];
        b   = im ? imm : m_gpr[s2];
        c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; r = 0;
        case (op)
            0:  r = m_sgpr;
            1:  r = im ? imm : a;
            2: begin
                r  = a + b;
                c  = (r > 65535);
                r  = r % 65536;
                sr = to_signed(a) + to_signed(b);
                v  = (sr > 32767) || (sr < -32768);
            end
            3: begin
                c  = (a < b);
                r  = (a - b + 65536) % 65536;
                sr = to_signed(a) - to_signed(b);
                v  = (sr > 32767) || (sr < -32768);
            end
            4: begin
                p      = longint'(a) * longint'(b);
                r      = int'(p % 65536);
                m_sgpr = int'(p / 65536);
                c      = (m_sgpr != 0);
                v      = c;
                lat    = 17;
            end
            5:  r = a | b;
            6:  r = a & b;
            7:  r = a ^ b;
            8:  r = 65535 - (a ^ b);
            9:  r = 65535 - (a & b);
            10: r = 65535 - (a | b);
            11: r = 65535 - (im ? imm : a);
            default: e = 1'b1;
        endcase
        if (!e) begin
            m_gpr[rd] = r;
            m_flags   = {r >= 32768, r == 0, c, v};
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 0;
        m_sgpr  = 0;
        m_flags = 4'b0000;
    endtask

    task automatic expect_reg(input string tag, input int idx, input int val);
        dbg_addr = 5'(idx);
        #1;
        check(tag, 32'(dbg_data), 32'(val));
    endtask

    // Issue one instruction, time its retirement and compare everything visible
    task automatic exec(input logic [31:0] ir, input bit hold);
        int  exp_lat, lat, ready_hi;
        bit  exp_err, seen, got_err;
        @(negedge clk);
        ir_in    = ir;
        ir_valid = 1'b1;
        check("ready_idle", 32'(ir_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            ir_valid = 1'b0;
            ir_in    = $urandom;
        end
        model_exec(ir, exp_lat, exp_err);
        seen = 1'b0; lat = 0; got_err = 1'b0; ready_hi = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen    = 1'b1;
                lat     = k;
                got_err = err;
                check("ready_retire", 32'(ir_ready), 32'd0);
            end else if (ir_ready) begin
                ready_hi++;
            end
        end
        ir_valid = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(got_err), 32'(exp_err));
        check("ready_busy", 32'(ready_hi), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("ready_back", 32'(ir_ready), 32'd1);
        check("flags", 32'(flags), 32'(m_flags));
        check("sgpr", 32'(sgpr), 32'(m_sgpr));
        expect_reg("gpr_rdst", int'(ir[26:22]), m_gpr[int'(ir[26:22])]);
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            expect_reg(tag, i, m_gpr[i]);
        end
    endtask

    initial begin
        int   op, dcnt;
        bit   hold;
        sys_rst  = 1'b1;
        ir_valid = 1'b0;
        ir_in    = 32'd0;
        dbg_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(ir_ready), 32'd0);
        sys_rst = 1'b0;
        #1;
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_sgpr", 32'(sgpr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(ir_ready), 32'd1);
        sweep_regs("rst_gpr");

        // mov/add immediate
        exec(enc_i(1, 1, 0, 16'h00FF), 1'b0);
        exec(enc_i(2, 2, 1, 16'h0001), 1'b0);
        expect_reg("add_r2", 2, 16'h0100);
        check("add_flags", 32'(flags), 32'h0);

        // sub borrow, then signed overflow on add
        exec(enc_i(1, 3, 0, 16'h0000), 1'b0);
        exec(enc_i(3, 4, 3, 16'h0001), 1'b0);
        expect_reg("sub_r4", 4, 16'hFFFF);
        check("sub_flags", 32'(flags), 32'b1010);
        exec(enc_i(1, 5, 0, 16'h7FFF), 1'b0);
        exec(enc_i(2, 5, 5, 16'h0001), 1'b0);
        expect_reg("ovf_r5", 5, 16'h8000);
        check("ovf_flags", 32'(flags), 32'b1001);

        // multiply with SGPR high half, then movsgpr
        exec(enc_i(1, 6, 0, 16'h1234), 1'b0);
        exec(enc_i(4, 7, 6, 16'h0100), 1'b0);
        expect_reg("mul_r7", 7, 16'h3400);
        check("mul_sgpr", 32'(sgpr), 32'h0012);
        check("mul_flags", 32'(flags), 32'b0011);
        exec(enc_i(0, 8, 0, 16'h0000), 1'b0);
        expect_reg("movsgpr_r8", 8, 16'h0012);

        // illegal opcode leaves R1 and flags alone
        exec(enc_i(31, 1, 2, 16'hABCD), 1'b0);
        expect_reg("illegal_r1", 1, 16'h00FF);
        check("illegal_flags", 32'(flags), 32'b0000);

        // valid held through a multiply: exactly one accept
        exec(enc_r(4, 11, 6, 5), 1'b1);
        expect_reg("hold_r1", 1, 16'h00FF);

        // aliasing: rdst equal to sources
        exec(enc_i(1, 9, 0, 16'h0F0F), 1'b0);
        exec(enc_r(7, 9, 9, 9), 1'b0);
        expect_reg("xor_r9", 9, 16'h0000);
        check("xor_flags", 32'(flags), 32'b0100);
        exec(enc_i(9, 10, 9, 16'hFFFF), 1'b0);
        expect_reg("nand_r10", 10, 16'hFFFF);

        // reset in the middle of a multiply
        exec(enc_i(1, 1, 0, 16'h00FF), 1'b0);
        @(negedge clk);
        ir_in    = enc_i(4, 2, 1, 16'h00FF);
        ir_valid = 1'b1;
        @(posedge clk);
        #1;
        ir_valid = 1'b0;
        repeat (2) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        model_reset();
        #1;
        check("mulrst_ready", 32'(ir_ready), 32'd1);
        check("mulrst_flags", 32'(flags), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("mulrst_no_done", 32'(dcnt), 32'd0);
        check("mulrst_sgpr", 32'(sgpr), 32'd0);
        expect_reg("mulrst_r2", 2, 0);
        expect_reg("mulrst_r1", 1, 0);

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 15);
            if (op >= 12) op = (op == 15) ? 31 : $urandom_range(12, 30);
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                exec(enc_i(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535)), hold);
            else
                exec(enc_r(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)), hold);
        end
        sweep_regs("final_gpr");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
